// File: rtl/upsample_pkg.sv
// Shared types for the upsample patch scheduler: FSM states,
// kernel geometry and the tap tag carried alongside buffer reads.
package upsample_pkg;

  typedef enum logic [1:0] {
    WAIT_ROWS,
    ISSUE,
    ROW_ADV,
    DONE
  } sched_state_t;

  localparam int KERNEL = 4;
  localparam int TAPS   = KERNEL * KERNEL;

  typedef struct packed {
    logic [3:0] idx;
    logic       last;
    logic [7:0] x;
    logic [6:0] y;
  } tap_tag_t;

endpackage

// File: rtl/pipeline.sv
// Generic register delay line with synchronous flush.
// Ports: clk, rst (async high), flush (sync clear), din -> dout after STAGES.
module pipeline #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= din;
      for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign dout = stage_q[STAGES-1];

endmodule

// File: rtl/tap_addr_gen.sv
// Kernel tap walker: kx inner / ky outer counters and buffer address add.
// Ports: clk, rst, clr (frame restart), step (one read issued), col_only
// (only the kx=3 column, used when COLUMN_REUSE_EN is defined in the top),
// patch_x/patch_y in; kx, ky, hor_addr, ver_addr, last_tap out.
module tap_addr_gen (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        step,
  input  logic        col_only,
  input  logic [7:0]  patch_x,
  input  logic [6:0]  patch_y,
  output logic [1:0]  kx,
  output logic [1:0]  ky,
  output logic [10:0] hor_addr,
  output logic [9:0]  ver_addr,
  output logic        last_tap
);

  logic [1:0] kx_q;
  logic [1:0] ky_q;

  // In column mode the kx counter stays parked at 0 and kx reads as 3
  assign kx       = col_only ? 2'd3 : kx_q;
  assign ky       = ky_q;
  assign last_tap = (ky_q == 2'd3) && (kx == 2'd3);
  assign hor_addr = {3'b000, patch_x} + {9'd0, kx};
  assign ver_addr = {3'b000, patch_y} + {8'd0, ky};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kx_q <= 2'd0;
      ky_q <= 2'd0;
    end else if (clr) begin
      kx_q <= 2'd0;
      ky_q <= 2'd0;
    end else if (step) begin
      if (last_tap) begin
        kx_q <= 2'd0;
        ky_q <= 2'd0;
      end else if (kx == 2'd3) begin
        kx_q <= 2'd0;
        ky_q <= ky_q + 2'd1;
      end else begin
        kx_q <= kx_q + 2'd1;
      end
    end
  end

endmodule

// File: rtl/upsample_patch_scheduler.sv
// Schedules 4x4 kernel reads from the filtered line buffer for the upsampler,
// tags returning pixels, and throttles the line writer.
// Ports: clk_in, rst_in (async high), frame_rst_in, line_done_in,
// patch_ready_in in; write_stall_out, read_valid_out, read_hor/ver_addr_out,
// tap_valid_out, tap_idx_out, patch_last_out, patch_x/y_out,
// frame_done_out, overflow_err_out out.
// Macro COLUMN_REUSE_EN: patches with patch_x>0 read only the kx=3 column.
module upsample_patch_scheduler
  import upsample_pkg::*;
#(
  parameter int FILTERED_WIDTH  = 131,
  parameter int FILTERED_HEIGHT = 99,
  parameter int READ_LATENCY    = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        frame_rst_in,
  input  logic        line_done_in,
  output logic        write_stall_out,
  input  logic        patch_ready_in,
  output logic        read_valid_out,
  output logic [10:0] read_hor_addr_out,
  output logic [9:0]  read_ver_addr_out,
  output logic        tap_valid_out,
  output logic [3:0]  tap_idx_out,
  output logic        patch_last_out,
  output logic [7:0]  patch_x_out,
  output logic [6:0]  patch_y_out,
  output logic        frame_done_out,
  output logic        overflow_err_out
);

  localparam logic [7:0] PX_LAST   = 8'(FILTERED_WIDTH - 4);
  localparam logic [6:0] PY_LAST   = 7'(FILTERED_HEIGHT - 4);
  localparam logic [7:0] LINES_MAX = 8'(FILTERED_HEIGHT);
  localparam logic [3:0] RL        = 4'(READ_LATENCY);
  localparam int         TAG_W     = $bits(tap_tag_t) + 1;

  sched_state_t state_q, state_d;
  logic [7:0]   lines_q, lines_d;
  logic [7:0]   px_q, px_d;
  logic [6:0]   py_q, py_d;
  logic         ovf_q, ovf_d;
  logic [3:0]   dcnt_q, dcnt_d;

  logic [7:0]   band;
  logic         band_full;
  logic         issue;
  logic         col_only;
  logic [1:0]   kx, ky;
  logic [10:0]  hor_addr;
  logic [9:0]   ver_addr;
  logic         last_tap;
  tap_tag_t     tag_in;
  tap_tag_t     tag_out;
  logic [TAG_W-1:0] pipe_out;

  // Rows held in the buffer that the current patch row still needs
  assign band      = lines_q - {1'b0, py_q};
  assign band_full = band >= 8'd4;
  assign issue     = (state_q == ISSUE);

`ifdef COLUMN_REUSE_EN
  assign col_only = (px_q != 8'd0);
`else
  assign col_only = 1'b0;
`endif

  tap_addr_gen u_addr (
    .clk      (clk_in),
    .rst      (rst_in),
    .clr      (frame_rst_in),
    .step     (issue),
    .col_only (col_only),
    .patch_x  (px_q),
    .patch_y  (py_q),
    .kx       (kx),
    .ky       (ky),
    .hor_addr (hor_addr),
    .ver_addr (ver_addr),
    .last_tap (last_tap)
  );

  always_comb begin
    tag_in = '0;
    if (issue) begin
      tag_in.idx  = {ky, kx};
      tag_in.last = last_tap;
      tag_in.x    = px_q;
      tag_in.y    = py_q;
    end
  end

  pipeline #(
    .WIDTH  (TAG_W),
    .STAGES (READ_LATENCY)
  ) u_tag_dly (
    .clk   (clk_in),
    .rst   (rst_in),
    .flush (frame_rst_in),
    .din   ({issue, tag_in}),
    .dout  (pipe_out)
  );

  assign tap_valid_out  = pipe_out[TAG_W-1];
  assign tag_out        = pipe_out[TAG_W-2:0];
  assign tap_idx_out    = tag_out.idx;
  assign patch_last_out = tag_out.last;
  assign patch_x_out    = tag_out.x;
  assign patch_y_out    = tag_out.y;

  assign read_valid_out    = issue;
  assign read_hor_addr_out = issue ? hor_addr : 11'd0;
  assign read_ver_addr_out = issue ? ver_addr : 10'd0;

  // Once the frame is finished the writer has nothing left to send
  assign write_stall_out = band_full ||
    ((state_q == DONE) && (lines_q >= LINES_MAX));
  assign frame_done_out   = (state_q == DONE) && (dcnt_q == RL);
  assign overflow_err_out = ovf_q;

  always_comb begin
    state_d = state_q;
    lines_d = lines_q;
    px_d    = px_q;
    py_d    = py_q;
    ovf_d   = ovf_q;
    dcnt_d  = dcnt_q;

    if (line_done_in) begin
      if (write_stall_out) ovf_d = 1'b1;
      else if (lines_q < LINES_MAX) lines_d = lines_q + 8'd1;
    end

    unique case (state_q)
      WAIT_ROWS: begin
        if (band_full && patch_ready_in) state_d = ISSUE;
      end
      ISSUE: begin
        if (last_tap) begin
          if (px_q < PX_LAST) begin
            px_d    = px_q + 8'd1;
            state_d = patch_ready_in ? ISSUE : WAIT_ROWS;
          end else begin
            state_d = ROW_ADV;
          end
        end
      end
      ROW_ADV: begin
        px_d    = 8'd0;
        py_d    = py_q + 7'd1;
        state_d = (py_q == PY_LAST) ? DONE : WAIT_ROWS;
      end
      DONE: begin
        // Counter saturates one past RL so the pulse fires once
        if (dcnt_q <= RL) dcnt_d = dcnt_q + 4'd1;
      end
      default: state_d = WAIT_ROWS;
    endcase

    if (frame_rst_in) begin
      state_d = WAIT_ROWS;
      lines_d = 8'd0;
      px_d    = 8'd0;
      py_d    = 7'd0;
      dcnt_d  = 4'd0;
      ovf_d   = ovf_q;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= WAIT_ROWS;
      lines_q <= 8'd0;
      px_q    <= 8'd0;
      py_q    <= 7'd0;
      ovf_q   <= 1'b0;
      dcnt_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      lines_q <= lines_d;
      px_q    <= px_d;
      py_q    <= py_d;
      ovf_q   <= ovf_d;
      dcnt_q  <= dcnt_d;
    end
  end

endmodule

// File: tb/tb_upsample_patch_scheduler.sv
// Scoreboard bench for upsample_patch_scheduler (7x6 filtered frame).
// Reads and returning taps are checked against a precomputed frame model.
module tb_upsample_patch_scheduler;

  localparam int W  = 7;
  localparam int H  = 6;
  localparam int RL = 2;
`ifdef COLUMN_REUSE_EN
  localparam int TAPS_FRAME = (H - 3) * (16 + (W - 4) * 4);
`else
  localparam int TAPS_FRAME = (H - 3) * (W - 3) * 16;
`endif

  logic        clk = 1'b0;
  logic        rst_in;
  logic        frame_rst_in;
  logic        line_done_in;
  logic        write_stall_out;
  logic        patch_ready_in;
  logic        read_valid_out;
  logic [10:0] read_hor_addr_out;
  logic [9:0]  read_ver_addr_out;
  logic        tap_valid_out;
  logic [3:0]  tap_idx_out;
  logic        patch_last_out;
  logic [7:0]  patch_x_out;
  logic [6:0]  patch_y_out;
  logic        frame_done_out;
  logic        overflow_err_out;

  upsample_patch_scheduler #(
    .FILTERED_WIDTH  (W),
    .FILTERED_HEIGHT (H),
    .READ_LATENCY    (RL)
  ) dut (
    .clk_in            (clk),
    .rst_in            (rst_in),
    .frame_rst_in      (frame_rst_in),
    .line_done_in      (line_done_in),
    .write_stall_out   (write_stall_out),
    .patch_ready_in    (patch_ready_in),
    .read_valid_out    (read_valid_out),
    .read_hor_addr_out (read_hor_addr_out),
    .read_ver_addr_out (read_ver_addr_out),
    .tap_valid_out     (tap_valid_out),
    .tap_idx_out       (tap_idx_out),
    .patch_last_out    (patch_last_out),
    .patch_x_out       (patch_x_out),
    .patch_y_out       (patch_y_out),
    .frame_done_out    (frame_done_out),
    .overflow_err_out  (overflow_err_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int hor;
    int ver;
    int idx;
    int last;
    int x;
    int y;
  } tap_t;

  tap_t exp_rd[$];
  tap_t exp_tap[$];
  int   rd_times[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int tap_cnt = 0;
  int done_cnt = 0;
  int lines_acc = 0;
  tap_t e;
  tap_t t;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Reference frame: patch rows, patch columns, then ky outer, kx inner
  function automatic void load_frame();
    tap_t m;
    exp_rd.delete();
    exp_tap.delete();
    rd_times.delete();
    for (int y = 0; y < H - 3; y++)
      for (int x = 0; x < W - 3; x++)
        for (int ky = 0; ky < 4; ky++)
          for (int kx = 0; kx < 4; kx++) begin
`ifdef COLUMN_REUSE_EN
            if (x > 0 && kx != 3) continue;
`endif
            m.hor  = x + kx;
            m.ver  = y + ky;
            m.idx  = ky * 4 + kx;
            m.last = (ky == 3 && kx == 3) ? 1 : 0;
            m.x    = x;
            m.y    = y;
            exp_rd.push_back(m);
            exp_tap.push_back(m);
          end
  endfunction

  always @(negedge clk) begin
    if (!rst_in) begin
      if (read_valid_out) begin
        rd_cnt++;
        if (exp_rd.size() == 0) check("rd_unexpected", 1, 0);
        else begin
          e = exp_rd.pop_front();
          check("rd_hor", int'(read_hor_addr_out), e.hor);
          check("rd_ver", int'(read_ver_addr_out), e.ver);
        end
        rd_times.push_back(cyc);
      end
      if (tap_valid_out) begin
        tap_cnt++;
        if (exp_tap.size() == 0) check("tap_unexpected", 1, 0);
        else begin
          t = exp_tap.pop_front();
          check("tap_idx", int'(tap_idx_out), t.idx);
          check("tap_last", int'(patch_last_out), t.last);
          check("tap_x", int'(patch_x_out), t.x);
          check("tap_y", int'(patch_y_out), t.y);
        end
        if (rd_times.size() != 0)
          check("tap_latency", cyc - rd_times.pop_front(), RL);
        else check("tap_no_read", 1, 0);
      end
      if (frame_done_out) begin
        done_cnt++;
        check("done_taps_pending", exp_tap.size(), 0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_line();
    if (!write_stall_out) lines_acc++;
    line_done_in = 1'b1;
    step();
    line_done_in = 1'b0;
  endtask

  task automatic wait_reads(input int n, input string name);
    for (int i = 0; i < 400; i++) begin
      if (rd_cnt >= n) break;
      step();
    end
    check(name, rd_cnt >= n, 1);
  endtask

  task automatic clear_sb();
    exp_rd.delete();
    exp_tap.delete();
    rd_times.delete();
    rd_cnt   = 0;
    tap_cnt  = 0;
    done_cnt = 0;
  endtask

  // Random writer and upsampler backpressure until the frame completes
  task automatic run_frame();
    for (int i = 0; i < 4000; i++) begin
      if (done_cnt != 0) break;
      patch_ready_in = ($urandom_range(0, 3) != 0);
      if (!line_done_in && !write_stall_out && lines_acc < H &&
          $urandom_range(0, 2) == 0) begin
        line_done_in = 1'b1;
        lines_acc++;
      end else begin
        line_done_in = 1'b0;
      end
      step();
    end
    line_done_in = 1'b0;
    patch_ready_in = 1'b1;
    repeat (6) step();
    check("frame_done_count", done_cnt, 1);
    check("frame_tap_count", tap_cnt, TAPS_FRAME);
    check("frame_reads_left", exp_rd.size(), 0);
  endtask

  int dly;

  initial begin
    rst_in = 1'b1;
    frame_rst_in = 1'b0;
    line_done_in = 1'b0;
    patch_ready_in = 1'b0;
    repeat (3) step();
    check("rst_read_valid", read_valid_out, 0);
    check("rst_tap_valid", tap_valid_out, 0);
    check("rst_stall", write_stall_out, 0);
    check("rst_overflow", overflow_err_out, 0);
    check("rst_frame_done", frame_done_out, 0);
    load_frame();
    rst_in = 1'b0;
    step();

    patch_ready_in = 1'b1;
    repeat (3) pulse_line();
    repeat (5) step();
    check("no_read_3_lines", rd_cnt, 0);
    check("no_stall_3_lines", write_stall_out, 0);

    pulse_line();
    dly = 0;
    while (!read_valid_out && dly < 10) begin
      step();
      dly++;
    end
    check("first_read_delay", dly, 1);
    check("stall_4_lines", write_stall_out, 1);

    step();
    patch_ready_in = 1'b0;
    pulse_line();
    check("overflow_set", overflow_err_out, 1);
    wait_reads(16, "patch0_reads");
    repeat (20) step();
    check("hold_not_ready", rd_cnt, 16);

    patch_ready_in = 1'b1;
    wait_reads(64, "row0_reads");
    dly = 0;
    while (write_stall_out && dly < 10) begin
      step();
      dly++;
    end
    check("stall_drop_row0", write_stall_out, 0);

    run_frame();
    check("stall_in_done", write_stall_out, 1);
    check("overflow_sticky", overflow_err_out, 1);

    frame_rst_in = 1'b1;
    step();
    frame_rst_in = 1'b0;
    clear_sb();
    lines_acc = 0;
    check("frst_overflow_kept", overflow_err_out, 1);
    check("frst_stall", write_stall_out, 0);

    load_frame();
    repeat (4) pulse_line();
    wait_reads(8, "midpatch_reads");
    frame_rst_in = 1'b1;
    step();
    frame_rst_in = 1'b0;
    clear_sb();
    lines_acc = 0;
    repeat (20) step();
    check("no_tap_after_frst", tap_cnt, 0);
    check("no_read_after_frst", rd_cnt, 0);

    load_frame();
    repeat (3) pulse_line();
    repeat (6) step();
    check("restart_needs_4", rd_cnt, 0);
    pulse_line();
    run_frame();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
